// File: rtl/uart_receiver_if.sv
// UART receive-side types and the receiver's bus interface.
// The package holds the uart_config_t register fields shared with the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_rate_t;

  typedef enum logic [1:0] {
    DATA_BITS_5 = 2'd0,
    DATA_BITS_6 = 2'd1,
    DATA_BITS_7 = 2'd2,
    DATA_BITS_8 = 2'd3
  } data_bits_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic {
    STOP_BITS_1 = 1'b0,
    STOP_BITS_2 = 1'b1
  } stop_bits_t;

  typedef struct packed {
    baud_rate_t baud_rate;
    data_bits_t data_bits;
    parity_t    parity;
    stop_bits_t stop_bits;
    logic       lsb_first;
  } uart_config_t;

endpackage

// Pin, configuration and frame-result signals between the register block and the receiver.
interface uart_receiver_if;
  import uart_pkg::*;

  logic         rx;
  uart_config_t uart_config;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         parity_error;
  logic         framing_error;
  logic         busy;

  // Register-block / pin side: drives the line and configuration, observes results.
  modport master (
    output rx, uart_config,
    input  rx_data, rx_valid, parity_error, framing_error, busy
  );

  // Receiver side.
  modport slave (
    input  rx, uart_config,
    output rx_data, rx_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// Serial-to-parallel UART receiver: 2-flop input synchroniser, mid-bit sampling,
// 5-8 data bits LSB- or MSB-first, optional parity, first-stop-bit check.
module uart_receiver #(
  parameter int unsigned CLK_FREQ = 1843200
) (
  input logic            clk,
  input logic            rst,
  uart_receiver_if.slave bus
);
  import uart_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Clock cycles per bit for a baud encoding; unknown encodings fall back to 9600.
  function automatic logic [31:0] cycles_per_bit(input baud_rate_t baud);
    logic [31:0] cpb;
    case (baud)
      BAUD_19200:  cpb = CLK_FREQ / 32'd19200;
      BAUD_38400:  cpb = CLK_FREQ / 32'd38400;
      BAUD_57600:  cpb = CLK_FREQ / 32'd57600;
      BAUD_115200: cpb = CLK_FREQ / 32'd115200;
      default:     cpb = CLK_FREQ / 32'd9600;
    endcase
    return cpb;
  endfunction

  // Clear every bit at or above the configured word length.
  function automatic logic [7:0] mask_word(input logic [7:0] word, input logic [3:0] nbits);
    logic [7:0] mask;
    mask = 8'hFF >> (4'd8 - nbits);
    return word & mask;
  endfunction

  state_t      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic [1:0]  sync_vld_q;   // rx_s_q reflects the real pin once bit 1 is set
  logic        armed_q;      // rx_s was seen high in IDLE, so a low now is a falling edge
  logic [31:0] cnt_q;
  logic [31:0] cpb_q;
  logic [31:0] half_q;
  logic [3:0]  nbits_q;
  logic [3:0]  bit_idx_q;
  parity_t     parity_q;
  logic        lsb_first_q;
  logic [7:0]  shift_q;
  logic        par_acc_q;
  logic        par_err_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        parity_error_q;
  logic        framing_error_q;
  logic        busy_q;

  logic [31:0] cpb_d;
  logic [2:0]  bit_pos_s;
  logic        last_bit_s;
  logic        has_parity_s;

  // Decode the live baud setting and the write position of the current data sample.
  always_comb begin
    cpb_d        = cycles_per_bit(bus.uart_config.baud_rate);
    last_bit_s   = (bit_idx_q == (nbits_q - 4'd1));
    has_parity_s = (parity_q == PARITY_ODD) || (parity_q == PARITY_EVEN);
    if (lsb_first_q) begin
      bit_pos_s = bit_idx_q[2:0];
    end else begin
      bit_pos_s = 3'(nbits_q - 4'd1 - bit_idx_q);
    end
  end

  // Synchroniser, receive FSM and registered frame results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      sync_vld_q      <= 2'b00;
      armed_q         <= 1'b0;
      cnt_q           <= 32'd0;
      cpb_q           <= 32'd0;
      half_q          <= 32'd0;
      nbits_q         <= 4'd8;
      bit_idx_q       <= 4'd0;
      parity_q        <= PARITY_NONE;
      lsb_first_q     <= 1'b1;
      shift_q         <= 8'd0;
      par_acc_q       <= 1'b0;
      par_err_q       <= 1'b0;
      rx_data_q       <= 8'd0;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      rx_meta_q  <= bus.rx;
      rx_s_q     <= rx_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      rx_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 32'd0;
          if (armed_q && !rx_s_q) begin
            state_q     <= S_START;
            busy_q      <= 1'b1;
            armed_q     <= 1'b0;
            cpb_q       <= cpb_d;
            half_q      <= cpb_d >> 1;
            nbits_q     <= 4'(bus.uart_config.data_bits) + 4'd5;
            parity_q    <= bus.uart_config.parity;
            lsb_first_q <= bus.uart_config.lsb_first;
          end else if (sync_vld_q[1] && rx_s_q) begin
            armed_q <= 1'b1;
          end else begin
            armed_q <= armed_q;
          end
        end
        S_START: begin
          if (cnt_q == half_q - 32'd1) begin
            cnt_q <= 32'd0;
            if (!rx_s_q) begin
              state_q   <= S_DATA;
              bit_idx_q <= 4'd0;
              shift_q   <= 8'd0;
              par_acc_q <= 1'b0;
              par_err_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == cpb_q - 32'd1) begin
            cnt_q              <= 32'd0;
            shift_q[bit_pos_s] <= rx_s_q;
            par_acc_q          <= par_acc_q ^ rx_s_q;
            bit_idx_q          <= bit_idx_q + 4'd1;
            if (last_bit_s) begin
              state_q <= has_parity_s ? S_PARITY : S_STOP;
            end else begin
              state_q <= S_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_PARITY: begin
          if (cnt_q == cpb_q - 32'd1) begin
            cnt_q   <= 32'd0;
            state_q <= S_STOP;
            if (parity_q == PARITY_ODD) begin
              par_err_q <= ~(par_acc_q ^ rx_s_q);
            end else begin
              par_err_q <= par_acc_q ^ rx_s_q;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == cpb_q - 32'd1) begin
            cnt_q           <= 32'd0;
            rx_data_q       <= mask_word(shift_q, nbits_q);
            parity_error_q  <= has_parity_s ? par_err_q : 1'b0;
            framing_error_q <= ~rx_s_q;
            rx_valid_q      <= 1'b1;
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 32'd0;
        end
      endcase
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 1.8432 MHz.
module tb_uart_receiver;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  uart_receiver_if ifc ();

  uart_receiver #(.CLK_FREQ(1843200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every rx_valid pulse and flag pulses wider than one cycle.
  int         vcnt = 0;
  int         long_pulse = 0;
  logic       prev_v = 1'b0;
  logic [7:0] cap_d  [0:15];
  logic       cap_pe [0:15];
  logic       cap_fe [0:15];
  int         cap_cyc[0:15];
  always @(negedge clk) begin
    if (ifc.rx_valid === 1'b1) begin
      if (vcnt < 16) begin
        cap_d[vcnt[3:0]]   <= ifc.rx_data;
        cap_pe[vcnt[3:0]]  <= ifc.parity_error;
        cap_fe[vcnt[3:0]]  <= ifc.framing_error;
        cap_cyc[vcnt[3:0]] <= cyc;
      end
      vcnt <= vcnt + 1;
      if (prev_v) long_pulse <= long_pulse + 1;
    end
    prev_v <= (ifc.rx_valid === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input baud_rate_t b, input data_bits_t d, input parity_t p,
                         input stop_bits_t s, input logic lsb);
    ifc.uart_config = '{baud_rate: b, data_bits: d, parity: p, stop_bits: s, lsb_first: lsb};
  endtask

  // Serialise one frame; par_bit < 0 means no parity bit. Leaves rx at the last stop level.
  task automatic send_frame(input logic [7:0] w, input int nbits, input int par_bit,
                            input logic lsb, input int stops, input int cpb, input logic stop_val);
    ifc.rx = 1'b0;
    tick(cpb);
    for (int i = 0; i < nbits; i++) begin
      ifc.rx = lsb ? w[i] : w[nbits-1-i];
      tick(cpb);
    end
    if (par_bit >= 0) begin
      ifc.rx = par_bit[0];
      tick(cpb);
    end
    ifc.rx = stop_val;
    tick(cpb);
    for (int s = 1; s < stops; s++) begin
      ifc.rx = 1'b1;
      tick(cpb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifc.rx = 1'b1;
    set_cfg(BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, 1'b1);
    tick(3);
    vectors++;
    if ({ifc.rx_data, ifc.rx_valid, ifc.parity_error, ifc.framing_error, ifc.busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               ifc.rx_data, ifc.rx_valid, ifc.parity_error, ifc.framing_error, ifc.busy);
    end
    rst = 1'b1;
    tick(10);
    vectors++;
    if (ifc.busy !== 1'b0 || vcnt != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got busy=%b valids=%0d, want busy=0 valids=0", ifc.busy, vcnt);
    end
  endtask

  task automatic test_basic_8n1();
    int v0, t0, lat;
    set_cfg(BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, 1'b1);
    v0 = vcnt;
    t0 = cyc;
    send_frame(8'hA5, 8, -1, 1'b1, 1, 16, 1'b1);
    tick(8);
    vectors++;
    if (vcnt != v0 + 1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d pulses, want 1", vcnt - v0);
    end else begin
      vectors++;
      if (cap_d[v0] !== 8'hA5 || cap_pe[v0] !== 1'b0 || cap_fe[v0] !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_data: got data=%h pe=%b fe=%b, want A5 0 0", cap_d[v0], cap_pe[v0], cap_fe[v0]);
      end
      // Fall is driven before edge t0+1; 2 sync + 8 to mid-start + 9*16 lands on edge t0+155.
      lat = cap_cyc[v0] - t0;
      vectors++;
      if (lat < 153 || lat > 156) begin
        miscompares++;
        $display("FAIL basic_latency: got %0d cycles, want 153..156", lat);
      end
    end
    vectors++;
    if (long_pulse != 0) begin
      miscompares++;
      $display("FAIL basic_pulse_width: got %0d extended pulses, want 0", long_pulse);
    end
  endtask

  task automatic test_parity_msb();
    int v0;
    set_cfg(BAUD_115200, DATA_BITS_7, PARITY_EVEN, STOP_BITS_1, 1'b0);
    v0 = vcnt;
    send_frame(8'h5A, 7, 0, 1'b0, 1, 16, 1'b1);
    tick(8);
    send_frame(8'h5A, 7, 1, 1'b0, 1, 16, 1'b1);
    tick(8);
    vectors++;
    if (vcnt != v0 + 2) begin
      miscompares++;
      $display("FAIL parity_count: got %0d pulses, want 2", vcnt - v0);
    end else begin
      vectors++;
      if (cap_d[v0] !== 8'h5A || cap_pe[v0] !== 1'b0 || cap_fe[v0] !== 1'b0) begin
        miscompares++;
        $display("FAIL parity_good: got data=%h pe=%b fe=%b, want 5A 0 0", cap_d[v0], cap_pe[v0], cap_fe[v0]);
      end
      vectors++;
      if (cap_d[v0+1] !== 8'h5A || cap_pe[v0+1] !== 1'b1 || cap_fe[v0+1] !== 1'b0) begin
        miscompares++;
        $display("FAIL parity_bad: got data=%h pe=%b fe=%b, want 5A 1 0", cap_d[v0+1], cap_pe[v0+1], cap_fe[v0+1]);
      end
    end
  endtask

  task automatic test_framing_break();
    int v0;
    set_cfg(BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, 1'b1);
    v0 = vcnt;
    send_frame(8'h81, 8, -1, 1'b1, 1, 16, 1'b0);
    tick(8);
    vectors++;
    if (vcnt != v0 + 1) begin
      miscompares++;
      $display("FAIL framing_count: got %0d pulses, want 1", vcnt - v0);
    end else begin
      vectors++;
      if (cap_d[v0] !== 8'h81 || cap_fe[v0] !== 1'b1 || cap_pe[v0] !== 1'b0) begin
        miscompares++;
        $display("FAIL framing_flags: got data=%h fe=%b pe=%b, want 81 1 0", cap_d[v0], cap_fe[v0], cap_pe[v0]);
      end
    end
    tick(50 * 16);
    vectors++;
    if (vcnt != v0 + 1 || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_break_hold: got pulses=%0d busy=%b, want 1 0", vcnt - v0, ifc.busy);
    end
    ifc.rx = 1'b1;
    tick(32);
    vectors++;
    if (vcnt != v0 + 1) begin
      miscompares++;
      $display("FAIL framing_release: got pulses=%0d, want 1", vcnt - v0);
    end
    send_frame(8'h33, 8, -1, 1'b1, 1, 16, 1'b1);
    tick(8);
    vectors++;
    if (vcnt != v0 + 2 || ifc.rx_data !== 8'h33 || ifc.framing_error !== 1'b0) begin
      miscompares++;
      $display("FAIL framing_recover: got pulses=%0d data=%h fe=%b, want 2 33 0", vcnt - v0, ifc.rx_data, ifc.framing_error);
    end
  endtask

  task automatic test_glitch();
    int   v0;
    logic idle_seen;
    set_cfg(BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, 1'b1);
    v0 = vcnt;
    idle_seen = 1'b0;
    ifc.rx = 1'b0;
    tick(4);
    ifc.rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (ifc.busy === 1'b0) idle_seen = 1'b1;
    end
    vectors++;
    if (idle_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy: got busy=%b after 8 cycles, want 0", ifc.busy);
    end
    tick(200);
    vectors++;
    if (vcnt != v0 || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_no_frame: got pulses=%0d busy=%b, want 0 0", vcnt - v0, ifc.busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    set_cfg(BAUD_9600, DATA_BITS_5, PARITY_ODD, STOP_BITS_2, 1'b1);
    v0 = vcnt;
    send_frame(8'h15, 5, 0, 1'b1, 2, 192, 1'b1);
    send_frame(8'h0A, 5, 1, 1'b1, 2, 192, 1'b1);
    tick(96);
    vectors++;
    if (vcnt != v0 + 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d pulses, want 2", vcnt - v0);
    end else begin
      vectors++;
      if (cap_d[v0] !== 8'h15 || cap_pe[v0] !== 1'b0 || cap_fe[v0] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_first: got data=%h pe=%b fe=%b, want 15 0 0", cap_d[v0], cap_pe[v0], cap_fe[v0]);
      end
      vectors++;
      if (cap_d[v0+1] !== 8'h0A || cap_pe[v0+1] !== 1'b0 || cap_fe[v0+1] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_second: got data=%h pe=%b fe=%b, want 0A 0 0", cap_d[v0+1], cap_pe[v0+1], cap_fe[v0+1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    set_cfg(BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, 1'b1);
    v0 = vcnt;
    ifc.rx = 1'b0;
    tick(16);
    ifc.rx = 1'b0; tick(16);
    ifc.rx = 1'b1; tick(16);
    ifc.rx = 1'b1; tick(16);
    ifc.rx = 1'b0; tick(8);
    vectors++;
    if (ifc.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_busy_before: got busy=%b, want 1", ifc.busy);
    end
    rst = 1'b0;
    tick(1);
    vectors++;
    if ({ifc.rx_data, ifc.rx_valid, ifc.parity_error, ifc.framing_error, ifc.busy} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs: got data=%h v=%b pe=%b fe=%b busy=%b, want all 0",
               ifc.rx_data, ifc.rx_valid, ifc.parity_error, ifc.framing_error, ifc.busy);
    end
    ifc.rx = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(20);
    vectors++;
    if (vcnt != v0) begin
      miscompares++;
      $display("FAIL midreset_no_valid: got %0d pulses, want 0", vcnt - v0);
    end
    send_frame(8'h3C, 8, -1, 1'b1, 1, 16, 1'b1);
    tick(8);
    vectors++;
    if (vcnt != v0 + 1 || ifc.rx_data !== 8'h3C || ifc.parity_error !== 1'b0 || ifc.framing_error !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got pulses=%0d data=%h pe=%b fe=%b, want 1 3C 0 0",
               vcnt - v0, ifc.rx_data, ifc.parity_error, ifc.framing_error);
    end
  endtask

  initial begin
    ifc.rx = 1'b1;
    set_cfg(BAUD_115200, DATA_BITS_8, PARITY_NONE, STOP_BITS_1, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_8n1();
    test_parity_msb();
    test_framing_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
